// File: rtl/dmd_pkg.sv
// rtl/dmd_pkg.sv - shared geometry, defaults and parser state type for the DMD frame loader
package dmd_pkg;
    localparam int DMD_W      = 128;
    localparam int DMD_H      = 64;
    localparam int DMD_PIXELS = DMD_W * DMD_H;
    localparam int DMD_ADDR_W = 13;
    localparam int DMD_PIX_W  = 4;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_CMD_FRAME = 8'h46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHECK,
        ST_FLIP_WAIT
    } state_t;
endpackage

// File: rtl/dmd_nibble_writer.sv
// rtl/dmd_nibble_writer.sv - splits a payload byte into two sequenced back-buffer pixel writes
module dmd_nibble_writer
    import dmd_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic [7:0]            data,
    input  logic                  back,
    output logic                  busy,
    output logic                  last_byte,
    output logic [DMD_ADDR_W-1:0] buf_addr,
    output logic [DMD_PIX_W-1:0]  buf_din,
    output logic                  buf0_we,
    output logic                  buf1_we
);
    logic [DMD_ADDR_W-1:0] addr_cnt;
    logic [DMD_PIX_W-1:0]  lo_nib;
    logic                  pending;

    assign busy      = pending;
    // A byte started at this address fills the final pixel slot.
    assign last_byte = (addr_cnt == DMD_ADDR_W'(DMD_PIXELS - 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= '0;
            lo_nib   <= '0;
            pending  <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
            buf0_we  <= 1'b0;
            buf1_we  <= 1'b0;
        end else begin
            buf0_we <= 1'b0;
            buf1_we <= 1'b0;
            if (clear) begin
                addr_cnt <= '0;
            end else if (pending) begin
                buf_addr <= addr_cnt;
                buf_din  <= lo_nib;
                buf0_we  <= ~back;
                buf1_we  <= back;
                addr_cnt <= addr_cnt + 1'b1;
                pending  <= 1'b0;
            end else if (start) begin
                buf_addr <= addr_cnt;
                buf_din  <= data[7:4];
                lo_nib   <= data[3:0];
                buf0_we  <= ~back;
                buf1_we  <= back;
                addr_cnt <= addr_cnt + 1'b1;
                pending  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmd_frame_loader.sv
// rtl/dmd_frame_loader.sv - parses framed UART images into the DMD back buffer and requests a flip
module dmd_frame_loader
    import dmd_pkg::*;
#(
    parameter int         TIMEOUT   = 2_000_000,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [7:0] CMD_FRAME = DEF_CMD_FRAME
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    input  logic                  display_frame,
    output logic [DMD_ADDR_W-1:0] buf_addr,
    output logic [DMD_PIX_W-1:0]  buf_din,
    output logic                  buf0_we,
    output logic                  buf1_we,
    output logic                  flip_req,
    output logic                  frame_ok,
    output logic                  frame_err
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic             back;
    logic [7:0]       csum;
    logic [TMO_W-1:0] tmo_cnt;
    logic             wr_busy;
    logic             wr_last;
    logic             wr_start;
    logic             wr_clear;
    logic             tmo_hit;

    assign wr_clear = (state == ST_IDLE) && rx_data_ready && (rx_data == SYNC_BYTE);
    // Strobes landing while the low nibble is still pending are dropped.
    assign wr_start = (state == ST_PAYLOAD) && rx_data_ready && !wr_busy;
    // Fires on the edge that would carry the counter into TIMEOUT-1.
    assign tmo_hit  = !rx_data_ready && (tmo_cnt == TMO_W'(TIMEOUT - 2));

    dmd_nibble_writer u_writer (
        .clk       (clk),
        .reset     (reset),
        .clear     (wr_clear),
        .start     (wr_start),
        .data      (rx_data),
        .back      (back),
        .busy      (wr_busy),
        .last_byte (wr_last),
        .buf_addr  (buf_addr),
        .buf_din   (buf_din),
        .buf0_we   (buf0_we),
        .buf1_we   (buf1_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            back      <= 1'b0;
            csum      <= '0;
            tmo_cnt   <= '0;
            flip_req  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_data_ready || state == ST_IDLE || state == ST_FLIP_WAIT)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (wr_clear) begin
                        back  <= ~display_frame;
                        csum  <= '0;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_data_ready) begin
                        if (rx_data == CMD_FRAME) begin
                            state <= ST_PAYLOAD;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (wr_start) begin
                        csum <= csum ^ rx_data;
                        if (wr_last)
                            state <= ST_CHECK;
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (rx_data_ready) begin
                        if (rx_data == csum) begin
                            flip_req <= 1'b1;
                            state    <= ST_FLIP_WAIT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_FLIP_WAIT: begin
                    if (display_frame == back) begin
                        flip_req <= 1'b0;
                        frame_ok <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmd_frame_loader.sv
// tb/tb_dmd_frame_loader.sv - scoreboard bench for the DMD frame loader
module tb_dmd_frame_loader;
    import dmd_pkg::*;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_data_ready = 1'b0;
    logic        display_frame = 1'b0;
    logic [12:0] buf_addr;
    logic [3:0]  buf_din;
    logic        buf0_we, buf1_we, flip_req, frame_ok, frame_err;

    always #5 clk = ~clk;

    dmd_frame_loader #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .display_frame (display_frame),
        .buf_addr      (buf_addr),
        .buf_din       (buf_din),
        .buf0_we       (buf0_we),
        .buf1_we       (buf1_we),
        .flip_req      (flip_req),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwr = 0;
    int n_err = 0;
    int n_ok = 0;
    int err_cyc = 0;
    int last_strobe = 0;
    bit flip_seen = 1'b0;
    logic [18:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (buf0_we || buf1_we) begin
            nwr++;
            if (sb.size() == 0)
                check("wr_unexpected", {13'd0, buf1_we, buf0_we, buf_addr, buf_din}, 32'd0);
            else
                check("wr", {13'd0, buf1_we, buf0_we, buf_addr, buf_din}, {13'd0, sb.pop_front()});
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (frame_ok) n_ok++;
        if (flip_req) flip_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        last_strobe   = cyc;
        tick(1);
        rx_data_ready = 1'b0;
        tick(2);
    endtask

    task automatic send_payload(input int nbytes, input bit bk, output logic [7:0] cs);
        logic [7:0] b;
        cs = '0;
        for (int k = 0; k < nbytes; k++) begin
            b = k[7:0];
            sb.push_back({bk, ~bk, 13'(2 * k), b[7:4]});
            sb.push_back({bk, ~bk, 13'(2 * k + 1), b[3:0]});
            cs = cs ^ b;
            send_byte(b);
        end
    endtask

    task automatic send_frame(input bit bk, input logic [7:0] cs_flip);
        logic [7:0] cs;
        int n0;
        n0 = nwr;
        send_byte(DEF_SYNC_BYTE);
        send_byte(DEF_CMD_FRAME);
        send_payload(4096, bk, cs);
        send_byte(cs ^ cs_flip);
        check("frame_writes", 32'(nwr - n0), 32'd8192);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int e0, o0, w0;
        logic [7:0] cs;

        tick(3);
        check("reset_outs", {14'd0, buf_addr, buf_din, buf0_we, buf1_we, flip_req, frame_ok, frame_err}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Frame 1: display 0 -> written to buffer 1
        send_frame(1'b1, 8'h00);
        check("flip_req_set", 32'(flip_req), 32'd1);
        w0 = nwr;
        send_byte(DEF_SYNC_BYTE);
        send_byte(DEF_CMD_FRAME);
        send_byte(8'h12);
        send_byte(8'h34);
        check("flipwait_nowr", 32'(nwr - w0), 32'd0);
        check("flipwait_hold", 32'(flip_req), 32'd1);
        o0 = n_ok;
        display_frame = 1'b1;
        @(negedge clk);
        check("flip_before", 32'(flip_req), 32'd1);
        @(negedge clk);
        check("flip_after", 32'(flip_req), 32'd0);
        check("ok_pulse", 32'(frame_ok), 32'd1);
        tick(5);
        check("ok_once", 32'(n_ok - o0), 32'd1);

        // Bad command byte, then valid frame into buffer 0
        e0 = n_err;
        send_byte(DEF_SYNC_BYTE);
        send_byte(8'h00);
        check("cmd_err_cnt", 32'(n_err - e0), 32'd1);
        check("cmd_err_lat", 32'(err_cyc - last_strobe), 32'd1);
        send_frame(1'b0, 8'h00);
        check("flip_req_f2", 32'(flip_req), 32'd1);
        o0 = n_ok;
        display_frame = 1'b0;
        tick(4);
        check("ok_f2", 32'(n_ok - o0), 32'd1);
        check("flip_clr_f2", 32'(flip_req), 32'd0);

        // Bad checksum
        e0 = n_err;
        flip_seen = 1'b0;
        send_frame(1'b1, 8'h01);
        tick(5);
        check("csum_err_cnt", 32'(n_err - e0), 32'd1);
        check("csum_noflip", 32'(flip_seen), 32'd0);

        // Stall after 100 payload bytes
        e0 = n_err;
        send_byte(DEF_SYNC_BYTE);
        send_byte(DEF_CMD_FRAME);
        send_payload(100, 1'b1, cs);
        for (int i = 0; i < 200 && n_err == e0; i++) tick(1);
        check("tmo_err_cnt", 32'(n_err - e0), 32'd1);
        check("tmo_err_lat", 32'(err_cyc - last_strobe), 32'(TMO));
        check("tmo_sb", 32'(sb.size()), 32'd0);

        // Reset mid-payload; addresses restart at 0
        send_byte(DEF_SYNC_BYTE);
        send_byte(DEF_CMD_FRAME);
        send_payload(10, 1'b1, cs);
        tick(2);
        e0 = n_err;
        reset = 1'b1;
        tick(1);
        check("rst_outs", {14'd0, buf_addr, buf_din, buf0_we, buf1_we, flip_req, frame_ok, frame_err}, 32'd0);
        reset = 1'b0;
        tick(3);
        check("rst_no_err", 32'(n_err - e0), 32'd0);

        send_frame(1'b1, 8'h00);
        check("flip_req_f4", 32'(flip_req), 32'd1);
        o0 = n_ok;
        display_frame = 1'b1;
        tick(4);
        check("ok_f4", 32'(n_ok - o0), 32'd1);
        check("flip_clr_f4", 32'(flip_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
